// File: rtl/pdm_demod.sv
// PDM demodulator: counts ones over a 2^WINDOW_LOG2-cycle window and reports the scaled level.
// Define PDM_DEMOD_SYNC_EN to pass pdm_in through a two-flop synchronizer before counting.
module pdm_demod #(
    parameter int WINDOW_LOG2 = 6,
    parameter int OUT_W       = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pdm_in,
    output logic [OUT_W-1:0] level_out,
    output logic             valid,
    output logic             sat,
    output logic             busy
);

    localparam int SHIFT = WINDOW_LOG2 - OUT_W;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                 state_q, state_d;
    logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
    logic [WINDOW_LOG2:0]   ones_q, ones_d;
    logic [OUT_W-1:0]       level_q, level_d;
    logic                   sat_q, sat_d;
    logic                   valid_q, valid_d;
    logic                   sample;
    logic                   take;
    logic [WINDOW_LOG2:0]   total;
    logic [OUT_W:0]         lvl_full;

    // Returns {sat, level}; only the all-ones window reaches 2^OUT_W.
    function automatic logic [OUT_W:0] clip(input logic [OUT_W:0] v);
        logic [OUT_W:0] max_v;
        max_v = {1'b0, {OUT_W{1'b1}}};
        if (v > max_v) begin
            clip = {1'b1, {OUT_W{1'b1}}};
        end else begin
            clip = {1'b0, v[OUT_W-1:0]};
        end
    endfunction

`ifdef PDM_DEMOD_SYNC_EN
    logic [1:0] sync_q;
    logic [1:0] prime_q, prime_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b00;
            prime_q <= 2'd0;
        end else begin
            sync_q  <= {sync_q[0], pdm_in};
            prime_q <= prime_d;
        end
    end

    // Hold off counting for two edges after entry so the window lines up with the delayed stream.
    always_comb begin
        prime_d = prime_q;
        if (state_q != ACCUM || !enable) begin
            prime_d = 2'd0;
        end else if (prime_q != 2'd2) begin
            prime_d = prime_q + 2'd1;
        end
    end

    assign sample = sync_q[1];
    assign take   = (state_q == ACCUM) && enable && (prime_q == 2'd2);
`else
    assign sample = pdm_in;
    assign take   = (state_q == ACCUM) && enable;
`endif

    assign total    = ones_q + {{WINDOW_LOG2{1'b0}}, sample};
    assign lvl_full = total[WINDOW_LOG2:SHIFT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ones_q  <= '0;
            level_q <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            level_q <= level_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ones_d  = ones_q;
        level_d = level_q;
        sat_d   = sat_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                ones_d = '0;
                if (enable) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ones_d  = '0;
                end else if (take) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        ones_d             = '0;
                        valid_d            = 1'b1;
                        {sat_d, level_d}   = clip(lvl_full);
                    end else begin
                        ones_d = total;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign level_out = level_q;
    assign sat       = sat_q;
    assign valid     = valid_q;
    assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_pdm_demod.sv
// Scoreboard bench for pdm_demod at default parameters (PDM_DEMOD_SYNC_EN undefined).
module tb_pdm_demod;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       pdm_in = 1'b0;
    logic [4:0] level_out;
    logic       valid, sat, busy;

    int         n_tests = 0;
    int         n_fail = 0;
    int         n_valid = 0;
    int         cyc = 0;
    int         entry = 0;
    logic [5:0] sb_q[$];
    int         vt[$];
    logic [5:0] exp_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pdm_demod dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .pdm_in   (pdm_in),
        .level_out(level_out),
        .valid    (valid),
        .sat      (sat),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic start_accum();
        enable = 1'b1;
        @(posedge clk);
        #1;
        entry = cyc;
    endtask

    // mode 0: first-order sigma-delta of a 5-bit code; 1: all ones; 2: all zeros.
    task automatic drive(input int mode, input int code, input int n);
        int   acc  = 0;
        int   ones = 0;
        int   lvl;
        logic b;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0: begin
                    acc += code;
                    if (acc >= 32) begin
                        acc -= 32;
                        b = 1'b1;
                    end else begin
                        b = 1'b0;
                    end
                end
                1:       b = 1'b1;
                default: b = 1'b0;
            endcase
            pdm_in = b;
            ones += int'(b);
            @(posedge clk);
            #1;
        end
        if (n == 64) begin
            lvl = ones >> 1;
            if (lvl > 31) sb_q.push_back({1'b1, 5'd31});
            else          sb_q.push_back({1'b0, 5'(lvl)});
        end
    endtask

    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            vt.push_back(cyc);
            if (sb_q.size() == 0) begin
                chk("spurious_valid", 32'd1, 32'd0);
            end else begin
                exp_e = sb_q.pop_front();
                chk("level", 32'(level_out), 32'(exp_e[4:0]));
                chk("sat", 32'(sat), 32'(exp_e[5]));
            end
        end
    end

    initial begin
        #2;
        chk("rst_level", 32'(level_out), 0);
        chk("rst_sat", 32'(sat), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        start_accum();
        chk("busy_accum", 32'(busy), 1);
        drive(0, 8, 64);
        chk("valid_pulse", 32'(valid), 1);
        chk("lat_first", 32'(cyc - entry), 64);
        drive(0, 26, 64);
        drive(0, 15, 64);
        drive(1, 0, 64);
        drive(2, 0, 64);
        drive(0, 20, 64);

        drive(0, 31, 30);
        enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("partial_level", 32'(level_out), 20);
        chk("partial_sat", 32'(sat), 0);
        chk("partial_busy", 32'(busy), 0);
        chk("partial_nvalid", 32'(n_valid), 6);

        start_accum();
        drive(0, 26, 64);
        chk("lat_reentry", 32'(cyc - entry), 64);
        drive(0, 31, 20);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_level", 32'(level_out), 0);
        chk("arst_sat", 32'(sat), 0);
        chk("arst_valid", 32'(valid), 0);
        chk("arst_busy", 32'(busy), 0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        chk("final_nvalid", 32'(n_valid), 7);
        chk("sb_empty", 32'(sb_q.size()), 0);
        chk("vt_count", 32'(vt.size()), 7);
        if (vt.size() >= 6) begin
            for (int i = 1; i < 6; i++) begin
                chk("spacing", 32'(vt[i] - vt[i-1]), 64);
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
